// File: rtl/host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : host_cmd_master
// Purpose  : Serializes one parallel command into a UART byte frame and
//            collects the 0/1/2-byte reply into a 16-bit result.
// Revision : 1.0 - initial release
// ============================================================================
module host_cmd_master #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TO_W           = 13
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VLD,
   input  logic [1:0]  CMD_TYPE,
   input  logic [3:0]  CMD_ADDR,
   input  logic [7:0]  CMD_DATA_A,
   input  logic [7:0]  CMD_DATA_B,
   input  logic [3:0]  CMD_FUN,
   output logic        CMD_RDY,
   output logic [7:0]  TX_DATA,
   output logic        TX_VLD,
   input  logic        TX_RDY,
   input  logic [7:0]  RX_P_DATA,
   input  logic        RX_D_VLD,
   output logic [15:0] RSP_DATA,
   output logic        RSP_VLD,
   output logic        TIMEOUT
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam logic [7:0]      c_HDR_WR   = 8'hAA;
   localparam logic [7:0]      c_HDR_RD   = 8'hBB;
   localparam logic [7:0]      c_HDR_ALU  = 8'hCC;
   localparam logic [7:0]      c_HDR_ALUN = 8'hDD;
   localparam logic [TO_W-1:0] c_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0] c_TO_ONE   = TO_W'(1);

   state_t          r_state,    w_state_nxt;
   logic [1:0]      r_type,     w_type_nxt;
   logic [3:0]      r_addr,     w_addr_nxt;
   logic [7:0]      r_data_a,   w_data_a_nxt;
   logic [7:0]      r_data_b,   w_data_b_nxt;
   logic [3:0]      r_fun,      w_fun_nxt;
   logic [1:0]      r_idx,      w_idx_nxt;
   logic [1:0]      r_rx_cnt,   w_rx_cnt_nxt;
   logic [TO_W-1:0] r_to_cnt,   w_to_cnt_nxt;
   logic            r_cmd_rdy,  w_cmd_rdy_nxt;
   logic [7:0]      r_tx_data,  w_tx_data_nxt;
   logic            r_tx_vld,   w_tx_vld_nxt;
   logic [15:0]     r_rsp_data, w_rsp_data_nxt;
   logic            r_rsp_vld,  w_rsp_vld_nxt;
   logic            r_timeout,  w_timeout_nxt;

   // Frame byte idx of a command; address/function go out zero-extended.
   function automatic logic [7:0] f_frame_byte(
      input logic [1:0] ty,
      input logic [1:0] idx,
      input logic [3:0] addr,
      input logic [7:0] da,
      input logic [7:0] db,
      input logic [3:0] fun
   );
      logic [7:0] b;
      b = 8'h00;
      case (ty)
         2'd0: begin
            case (idx)
               2'd0:    b = c_HDR_WR;
               2'd1:    b = {4'h0, addr};
               default: b = da;
            endcase
         end
         2'd1: b = (idx == 2'd0) ? c_HDR_RD : {4'h0, addr};
         2'd2: begin
            case (idx)
               2'd0:    b = c_HDR_ALU;
               2'd1:    b = da;
               2'd2:    b = db;
               default: b = {4'h0, fun};
            endcase
         end
         default: b = (idx == 2'd0) ? c_HDR_ALUN : {4'h0, fun};
      endcase
      return b;
   endfunction

   function automatic logic [1:0] f_last_idx(input logic [1:0] ty);
      logic [1:0] n;
      case (ty)
         2'd0:    n = 2'd2;
         2'd2:    n = 2'd3;
         default: n = 2'd1;
      endcase
      return n;
   endfunction

   function automatic logic [1:0] f_num_reply(input logic [1:0] ty);
      logic [1:0] n;
      case (ty)
         2'd0:    n = 2'd0;
         2'd1:    n = 2'd1;
         default: n = 2'd2;
      endcase
      return n;
   endfunction

   always_comb begin
      w_state_nxt    = r_state;
      w_type_nxt     = r_type;
      w_addr_nxt     = r_addr;
      w_data_a_nxt   = r_data_a;
      w_data_b_nxt   = r_data_b;
      w_fun_nxt      = r_fun;
      w_idx_nxt      = r_idx;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_to_cnt_nxt   = r_to_cnt;
      w_cmd_rdy_nxt  = r_cmd_rdy;
      w_tx_data_nxt  = r_tx_data;
      w_tx_vld_nxt   = r_tx_vld;
      w_rsp_data_nxt = r_rsp_data;
      w_rsp_vld_nxt  = 1'b0;
      w_timeout_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cmd_rdy_nxt = 1'b1;
            if (CMD_VLD && r_cmd_rdy) begin
               w_type_nxt     = CMD_TYPE;
               w_addr_nxt     = CMD_ADDR;
               w_data_a_nxt   = CMD_DATA_A;
               w_data_b_nxt   = CMD_DATA_B;
               w_fun_nxt      = CMD_FUN;
               w_idx_nxt      = 2'd0;
               w_rx_cnt_nxt   = 2'd0;
               w_to_cnt_nxt   = '0;
               w_rsp_data_nxt = 16'h0000;
               w_tx_data_nxt  = f_frame_byte(CMD_TYPE, 2'd0, CMD_ADDR,
                                             CMD_DATA_A, CMD_DATA_B, CMD_FUN);
               w_tx_vld_nxt   = 1'b1;
               w_cmd_rdy_nxt  = 1'b0;
               w_state_nxt    = ST_SEND;
            end
         end

         ST_SEND: begin
            if (TX_RDY) begin
               if (r_idx == f_last_idx(r_type)) begin
                  w_tx_vld_nxt = 1'b0;
                  w_to_cnt_nxt = '0;
                  if (r_type == 2'd0) begin
                     w_state_nxt   = ST_DONE;
                     w_rsp_vld_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_WAIT_RSP;
                  end
               end else begin
                  w_idx_nxt     = r_idx + 2'd1;
                  w_tx_data_nxt = f_frame_byte(r_type, r_idx + 2'd1, r_addr,
                                               r_data_a, r_data_b, r_fun);
               end
            end
         end

         ST_WAIT_RSP: begin
            // A byte arriving on the terminal count wins over the timeout.
            if (RX_D_VLD) begin
               w_to_cnt_nxt = '0;
               w_rx_cnt_nxt = r_rx_cnt + 2'd1;
               if (r_rx_cnt == 2'd0) begin
                  w_rsp_data_nxt[7:0] = RX_P_DATA;
               end else begin
                  w_rsp_data_nxt[15:8] = RX_P_DATA;
               end
               if ((r_rx_cnt + 2'd1) == f_num_reply(r_type)) begin
                  w_state_nxt   = ST_DONE;
                  w_rsp_vld_nxt = 1'b1;
               end
            end else if (r_to_cnt == c_TO_LAST) begin
               w_state_nxt   = ST_DONE;
               w_timeout_nxt = 1'b1;
            end else begin
               w_to_cnt_nxt = r_to_cnt + c_TO_ONE;
            end
         end

         ST_DONE: begin
            w_state_nxt   = ST_IDLE;
            w_cmd_rdy_nxt = 1'b1;
         end

         default: begin
            w_state_nxt   = ST_IDLE;
            w_cmd_rdy_nxt = 1'b1;
            w_tx_vld_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_type     <= 2'd0;
         r_addr     <= 4'h0;
         r_data_a   <= 8'h00;
         r_data_b   <= 8'h00;
         r_fun      <= 4'h0;
         r_idx      <= 2'd0;
         r_rx_cnt   <= 2'd0;
         r_to_cnt   <= '0;
         r_cmd_rdy  <= 1'b1;
         r_tx_data  <= 8'h00;
         r_tx_vld   <= 1'b0;
         r_rsp_data <= 16'h0000;
         r_rsp_vld  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_type     <= w_type_nxt;
         r_addr     <= w_addr_nxt;
         r_data_a   <= w_data_a_nxt;
         r_data_b   <= w_data_b_nxt;
         r_fun      <= w_fun_nxt;
         r_idx      <= w_idx_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_to_cnt   <= w_to_cnt_nxt;
         r_cmd_rdy  <= w_cmd_rdy_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_vld   <= w_tx_vld_nxt;
         r_rsp_data <= w_rsp_data_nxt;
         r_rsp_vld  <= w_rsp_vld_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign CMD_RDY  = r_cmd_rdy;
   assign TX_DATA  = r_tx_data;
   assign TX_VLD   = r_tx_vld;
   assign RSP_DATA = r_rsp_data;
   assign RSP_VLD  = r_rsp_vld;
   assign TIMEOUT  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_host_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_cmd_master
// Purpose  : Directed and randomized transactions against a frame/reply model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_cmd_master;

   localparam int TO = 16;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CMD_VLD = 1'b0;
   logic [1:0]  CMD_TYPE = '0;
   logic [3:0]  CMD_ADDR = '0;
   logic [7:0]  CMD_DATA_A = '0;
   logic [7:0]  CMD_DATA_B = '0;
   logic [3:0]  CMD_FUN = '0;
   logic        CMD_RDY;
   logic [7:0]  TX_DATA;
   logic        TX_VLD;
   logic        TX_RDY = 1'b0;
   logic [7:0]  RX_P_DATA = '0;
   logic        RX_D_VLD = 1'b0;
   logic [15:0] RSP_DATA;
   logic        RSP_VLD;
   logic        TIMEOUT;

   int errors = 0;
   int checks = 0;

   host_cmd_master #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR),
      .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B), .CMD_FUN(CMD_FUN),
      .CMD_RDY(CMD_RDY),
      .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_RDY(TX_RDY),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RSP_DATA(RSP_DATA), .RSP_VLD(RSP_VLD), .TIMEOUT(TIMEOUT)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd_noise();
      CMD_VLD    = 1'($urandom_range(0, 1));
      CMD_TYPE   = 2'($urandom);
      CMD_ADDR   = 4'($urandom);
      CMD_DATA_A = 8'($urandom);
      CMD_DATA_B = 8'($urandom);
      CMD_FUN    = 4'($urandom);
   endtask

   // One complete transaction. nsend < expected reply count means the
   // responder goes silent and a timeout is expected.
   task automatic do_txn(input logic [1:0] ty, input logic [3:0] ad,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fn, input int rdy_mode,
                         input int nsend, input int gap0, input int gap1,
                         input logic [7:0] r0, input logic [7:0] r1,
                         input bit noise);
      logic [7:0]  fr [4];
      logic [7:0]  rb [2];
      logic [15:0] exp_rsp;
      int          nb, nrep, stall, w, g, n;
      bit          xfer, to_exp;

      case (ty)
         2'd0: begin fr = '{8'hAA, {4'h0, ad}, a, 8'h00}; nb = 3; nrep = 0; end
         2'd1: begin fr = '{8'hBB, {4'h0, ad}, 8'h00, 8'h00}; nb = 2; nrep = 1; end
         2'd2: begin fr = '{8'hCC, a, b, {4'h0, fn}}; nb = 4; nrep = 2; end
         default: begin fr = '{8'hDD, {4'h0, fn}, 8'h00, 8'h00}; nb = 2; nrep = 2; end
      endcase
      rb[0]   = r0;
      rb[1]   = r1;
      to_exp  = (nsend < nrep);
      exp_rsp = 16'h0000;

      w = 0;
      while (!CMD_RDY && w < 50) begin @(negedge CLK); w++; end
      chk("cmd_rdy_idle", CMD_RDY, 1);
      CMD_TYPE = ty; CMD_ADDR = ad; CMD_DATA_A = a; CMD_DATA_B = b; CMD_FUN = fn;
      CMD_VLD = 1'b1;
      @(negedge CLK);
      CMD_VLD = 1'b0;
      chk("cmd_rdy_busy", CMD_RDY, 0);

      for (int i = 0; i < nb; i++) begin
         stall = (rdy_mode == 2 && i == 1) ? 5 : 0;
         xfer = 1'b0;
         for (int c = 0; c < 64 && !xfer; c++) begin
            chk("tx_vld", TX_VLD, 1);
            chk("tx_data", TX_DATA, fr[i]);
            if (rdy_mode == 1) TX_RDY = 1'($urandom_range(0, 1));
            else               TX_RDY = (c >= stall);
            if (noise) begin
               cmd_noise();
               RX_D_VLD  = 1'($urandom_range(0, 1));
               RX_P_DATA = 8'($urandom);
            end
            xfer = TX_RDY;
            @(negedge CLK);
         end
         chk("tx_transfer", 32'(xfer), 1);
      end
      TX_RDY = 1'b0;
      RX_D_VLD = 1'b0;
      chk("tx_vld_end", TX_VLD, 0);

      for (int k = 0; k < nrep && k < nsend; k++) begin
         g = (k == 0) ? gap0 : gap1;
         for (int c = 0; c < g; c++) begin
            chk("no_early_end", {RSP_VLD, TIMEOUT}, 0);
            if (noise) cmd_noise();
            @(negedge CLK);
         end
         RX_P_DATA = rb[k];
         RX_D_VLD = 1'b1;
         if (noise) cmd_noise();
         @(negedge CLK);
         RX_D_VLD = 1'b0;
         if (k == 0) exp_rsp[7:0] = rb[0];
         else        exp_rsp[15:8] = rb[1];
      end

      if (to_exp) begin
         n = 0;
         while (!TIMEOUT && n < 4 * TO) begin
            chk("rsp_vld_before_to", RSP_VLD, 0);
            if (noise) cmd_noise();
            @(negedge CLK);
            n++;
         end
         chk("timeout_latency", n, TO);
         chk("timeout_pulse", TIMEOUT, 1);
         chk("rsp_vld_on_to", RSP_VLD, 0);
      end else begin
         chk("rsp_vld", RSP_VLD, 1);
         chk("timeout_low", TIMEOUT, 0);
      end
      CMD_VLD = 1'b0;
      chk("rsp_data", RSP_DATA, exp_rsp);
      @(negedge CLK);
      chk("pulse_end", {RSP_VLD, TIMEOUT}, 0);
      chk("cmd_rdy_back", CMD_RDY, 1);
      chk("rsp_hold", RSP_DATA, exp_rsp);

      RX_P_DATA = ~exp_rsp[7:0];
      RX_D_VLD = 1'b1;
      @(negedge CLK);
      RX_D_VLD = 1'b0;
      chk("rsp_hold_idle_rx", RSP_DATA, exp_rsp);
      chk("idle_no_pulse", {RSP_VLD, TIMEOUT, TX_VLD}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed=stuck expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] ty;
      int         ns;

      repeat (2) @(negedge CLK);
      chk("rst_cmd_rdy", CMD_RDY, 1);
      chk("rst_tx_vld", TX_VLD, 0);
      chk("rst_tx_data", TX_DATA, 0);
      chk("rst_rsp_data", RSP_DATA, 0);
      chk("rst_pulses", {RSP_VLD, TIMEOUT}, 0);
      RST = 1'b0;
      @(negedge CLK);

      // RF read, then RF write (also shows RSP_DATA cleared on accept)
      do_txn(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 0, 1, 12, 0, 8'h7E, 8'h00, 0);
      do_txn(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
      // ALU with and without operands
      do_txn(2'd2, 4'd0, 8'h12, 8'h34, 4'd2, 0, 2, 3, 1, 8'h48, 8'h03, 0);
      do_txn(2'd3, 4'd0, 8'h00, 8'h00, 4'd1, 0, 2, 0, 0, 8'h5A, 8'hC3, 0);
      // backpressure on the second byte with busy-time command/reply noise
      do_txn(2'd2, 4'd9, 8'hF0, 8'h0F, 4'd7, 2, 2, 2, 2, 8'h11, 8'h22, 1);
      // timeout after one reply byte, and with no reply at all
      do_txn(2'd2, 4'd0, 8'h01, 8'h02, 4'd3, 0, 1, 2, 0, 8'hAB, 8'h00, 0);
      do_txn(2'd3, 4'd0, 8'h00, 8'h00, 4'hF, 0, 0, 0, 0, 8'h00, 8'h00, 0);
      // replies landing exactly on the terminal count
      do_txn(2'd1, 4'hF, 8'h00, 8'h00, 4'd0, 0, 1, TO - 1, 0, 8'h99, 8'h00, 0);
      do_txn(2'd2, 4'd1, 8'hAA, 8'h55, 4'd4, 1, 2, TO - 1, TO - 1, 8'h3E, 8'hE3, 0);

      // reset while the third byte of an ALU frame is on the wire
      CMD_TYPE = 2'd2; CMD_ADDR = 4'd0; CMD_DATA_A = 8'h61; CMD_DATA_B = 8'h62; CMD_FUN = 4'd5;
      CMD_VLD = 1'b1;
      @(negedge CLK);
      CMD_VLD = 1'b0;
      TX_RDY = 1'b1;
      repeat (2) @(negedge CLK);
      chk("pre_rst_byte2", TX_DATA, 8'h62);
      RST = 1'b1;
      TX_RDY = 1'b0;
      #1;
      chk("rst_abort_tx_vld", TX_VLD, 0);
      chk("rst_abort_cmd_rdy", CMD_RDY, 1);
      chk("rst_abort_tx_data", TX_DATA, 0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      chk("rst_abort_no_pulse", {RSP_VLD, TIMEOUT}, 0);
      do_txn(2'd2, 4'd0, 8'h61, 8'h62, 4'd5, 0, 2, 1, 1, 8'h0D, 8'hD0, 0);

      for (int t = 0; t < 25; t++) begin
         ty = 2'($urandom);
         ns = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : 2;
         do_txn(ty, 4'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
                $urandom_range(0, 2), ns, $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
